// File: rtl/usb_arb_pkg.sv
// Shared definitions for usb_packet_arbiter: overflow marker layout and
// output source-select encoding.
package usb_arb_pkg;

  localparam logic [7:0] OVF_TAG = 8'hFF;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_TRACE  = 2'd1,
    SEL_STATUS = 2'd2
  } sel_t;

  typedef struct packed {
    logic [7:0]  tag;
    logic [7:0]  zero;
    logic [15:0] count;
  } marker_t;

  function automatic logic [31:0] make_marker(input logic [7:0] tag, input logic [15:0] count);
    marker_t m;
    m.tag   = tag;
    m.zero  = 8'h00;
    m.count = count;
    return m;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Single-clock trace FIFO with registered occupancy. The head word is read
// combinationally so a word written on one cycle can be consumed on the next.
module trace_fifo #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full
);
  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          wr_ok;
  logic          rd_ok;

  // Full/empty come from the registered level only: a same-cycle pop never
  // makes room for that cycle's write.
  assign empty   = (level_reg == '0);
  assign full    = (level_reg == (AW+1)'(DEPTH));
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg];
  assign level   = level_reg;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/usb_packet_arbiter.sv
// Arbitrates the USB FIFO link between a buffered trace stream and a status stream.
// Define USB_ARB_OVF_MARKER_EN to insert overflow marker words into the trace FIFO.
module usb_packet_arbiter #(
  parameter int         FIFO_AW    = 4,
  parameter int         STARVE_MAX = 8,
  parameter logic [7:0] OVF_TAG    = 8'hFF
) (
  input  logic               mclk,
  input  logic               reset_n,
  input  logic [31:0]        trace_data,
  input  logic               trace_strobe,
  input  logic [31:0]        status_data,
  input  logic               status_valid,
  output logic               status_ready,
  output logic [31:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [15:0]        ovf_count
);
  import usb_arb_pkg::*;

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [31:0]   out_data_reg;
  logic          out_valid_reg;
  logic [15:0]   ovf_reg;
  logic [15:0]   ovf_next;
  logic [SW-1:0] starve_reg;
  logic [SW-1:0] starve_next;

  logic          fifo_wr_en;
  logic [31:0]   fifo_wr_data;
  logic          fifo_rd_en;
  logic [31:0]   fifo_head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          marker_slot;
  logic          load_slot;
  sel_t          sel;

  trace_fifo #(
    .AW (FIFO_AW),
    .DW (32)
  ) u_fifo (
    .clk     (mclk),
    .rst_n   (reset_n),
    .wr_en   (fifo_wr_en),
    .wr_data (fifo_wr_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_head),
    .level   (fifo_level),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // FIFO write port: a pending marker has priority; the strobe arriving with it is lost.
  always_comb begin
    fifo_wr_en   = 1'b0;
    fifo_wr_data = trace_data;
    ovf_next     = ovf_reg;
    marker_slot  = 1'b0;
`ifdef USB_ARB_OVF_MARKER_EN
    marker_slot  = (ovf_reg != 16'd0) && !fifo_full;
`endif
    if (marker_slot) begin
      fifo_wr_en   = 1'b1;
      fifo_wr_data = make_marker(OVF_TAG, ovf_reg);
      ovf_next     = trace_strobe ? 16'd1 : 16'd0;
    end else if (trace_strobe && !fifo_full) begin
      fifo_wr_en   = 1'b1;
    end else if (trace_strobe && (ovf_reg != 16'hFFFF)) begin
      ovf_next     = ovf_reg + 16'd1;
    end
  end

  always_comb begin
    load_slot = !out_valid_reg || out_ready;
    sel       = SEL_NONE;
    if (status_valid && (fifo_empty || (starve_reg == SW'(STARVE_MAX)))) begin
      sel = SEL_STATUS;
    end else if (!fifo_empty) begin
      sel = SEL_TRACE;
    end
    status_ready = load_slot && (sel == SEL_STATUS);
    fifo_rd_en   = load_slot && (sel == SEL_TRACE);

    starve_next = starve_reg;
    if (!status_valid || status_ready) begin
      starve_next = '0;
    end else if (fifo_rd_en && (starve_reg != SW'(STARVE_MAX))) begin
      starve_next = starve_reg + SW'(1);
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      ovf_reg       <= '0;
      starve_reg    <= '0;
    end else begin
      ovf_reg    <= ovf_next;
      starve_reg <= starve_next;
      if (load_slot) begin
        case (sel)
          SEL_STATUS: begin
            out_data_reg  <= status_data;
            out_valid_reg <= 1'b1;
          end
          SEL_TRACE: begin
            out_data_reg  <= fifo_head;
            out_valid_reg <= 1'b1;
          end
          default: out_valid_reg <= 1'b0;
        endcase
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign ovf_count = ovf_reg;

endmodule

// File: tb/tb_usb_packet_arbiter.sv
// Scoreboard bench for usb_packet_arbiter: directed stimulus pushes expected output
// words; an independent monitor pops and compares every accepted output word.
module tb_usb_packet_arbiter;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] trace_data = '0;
  logic        trace_strobe = 1'b0;
  logic [31:0] status_data = '0;
  logic        status_valid = 1'b0;
  logic        status_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  fifo_level;
  logic [15:0] ovf_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] st_q[$];
  logic        st_taken = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] hold_data = '0;
  logic [31:0] exp_word;

  usb_packet_arbiter dut (
    .mclk         (mclk),
    .reset_n      (reset_n),
    .trace_data   (trace_data),
    .trace_strobe (trace_strobe),
    .status_data  (status_data),
    .status_valid (status_valid),
    .status_ready (status_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_level   (fifo_level),
    .ovf_count    (ovf_count)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] w);
    trace_data   = w;
    trace_strobe = 1'b1;
    tick();
    trace_strobe = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d words outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Status source: presents the head of st_q, advances once per accepted handshake.
  initial begin
    forever begin
      @(negedge mclk);
      st_taken = status_valid && status_ready;
      @(posedge mclk);
      #1;
      if (st_taken && st_q.size() != 0) void'(st_q.pop_front());
      if (st_q.size() != 0) begin
        status_valid = 1'b1;
        status_data  = st_q[0];
      end else begin
        status_valid = 1'b0;
      end
    end
  end

  // Monitor: compares accepted words and checks that held words stay stable.
  initial begin
    forever begin
      @(negedge mclk);
      if (!reset_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", {31'b0, out_valid}, 32'd1);
          check("hold_data", out_data, hold_data);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h expected none", out_data);
          end else begin
            exp_word = exp_q.pop_front();
            $display("xfer data=%h expected=%h", out_data, exp_word);
            check("out_data", out_data, exp_word);
          end
        end
        hold      = out_valid && !out_ready;
        hold_data = out_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_fifo_level", {27'b0, fifo_level}, 32'd0);
    check("rst_ovf_count", {16'b0, ovf_count}, 32'd0);
    check("rst_status_ready", {31'b0, status_ready}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: three trace words, latency N+2
    out_ready = 1'b1;
    exp_q.push_back(32'hA000_000A);
    exp_q.push_back(32'hB000_000B);
    exp_q.push_back(32'hC000_000C);
    trace_data = 32'hA000_000A; trace_strobe = 1'b1; tick();
    check("t1_valid_n1", {31'b0, out_valid}, 32'd0);
    trace_data = 32'hB000_000B; tick();
    check("t1_valid_n2", {31'b0, out_valid}, 32'd1);
    check("t1_data_n2", out_data, 32'hA000_000A);
    trace_data = 32'hC000_000C; tick();
    trace_strobe = 1'b0;
    wait_drain(20, "t1_drain");
    repeat (2) tick();
    check("t1_level_end", {27'b0, fifo_level}, 32'd0);
    check("t1_valid_end", {31'b0, out_valid}, 32'd0);

    // 2: overflow with output stalled; P occupies the output register first
    out_ready = 1'b0;
    exp_q.push_back(32'h1111_1111);
    strobe(32'h1111_1111);
    repeat (3) tick();
    for (int i = 0; i < 20; i++) begin
      trace_data = 32'h2000_0000 + i; trace_strobe = 1'b1; tick();
    end
    trace_strobe = 1'b0;
    tick();
    check("t2_level_full", {27'b0, fifo_level}, 32'd16);
    check("t2_ovf", {16'b0, ovf_count}, 32'd4);
    check("t2_held", out_data, 32'h1111_1111);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h2000_0000 + i);
`ifdef USB_ARB_OVF_MARKER_EN
    exp_q.push_back(32'hFF00_0004);
`endif
    out_ready = 1'b1;
    wait_drain(60, "t2_drain");
    repeat (3) tick();
`ifdef USB_ARB_OVF_MARKER_EN
    check("t2_ovf_after", {16'b0, ovf_count}, 32'd0);
`else
    check("t2_ovf_after", {16'b0, ovf_count}, 32'd4);
`endif
    check("t2_level_end", {27'b0, fifo_level}, 32'd0);

    // 3: starvation limit with a full FIFO and status waiting
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      trace_data = 32'h3000_0000 + i; trace_strobe = 1'b1; tick();
    end
    trace_strobe = 1'b0;
    repeat (2) tick();
    check("t3_level_full", {27'b0, fifo_level}, 32'd16);
    st_q.push_back(32'h5A5A_0000);
    st_q.push_back(32'h5A5A_0001);
    for (int i = 0; i <= 8; i++) exp_q.push_back(32'h3000_0000 + i);
    exp_q.push_back(32'h5A5A_0000);
    for (int i = 9; i <= 16; i++) exp_q.push_back(32'h3000_0000 + i);
    exp_q.push_back(32'h5A5A_0001);
    repeat (3) tick();
    out_ready = 1'b1;
    wait_drain(60, "t3_drain");
    repeat (3) tick();

    // 4: status only, out_ready toggling
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st_q.push_back(32'hC0DE_0000 + i);
      exp_q.push_back(32'hC0DE_0000 + i);
    end
    for (int i = 0; i < 16; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    out_ready = 1'b1;
    wait_drain(20, "t4_drain");
    repeat (3) tick();

    // 5: full FIFO, overflow pending, strobe on the pop cycle
    out_ready = 1'b0;
    exp_q.push_back(32'h5000_0000);
    strobe(32'h5000_0000);
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      trace_data = 32'h5100_0000 + i; trace_strobe = 1'b1; tick();
    end
    trace_data = 32'h5F00_0000; tick();
    trace_strobe = 1'b0;
    tick();
    check("t5_level_full", {27'b0, fifo_level}, 32'd16);
`ifdef USB_ARB_OVF_MARKER_EN
    check("t5_ovf_pend", {16'b0, ovf_count}, 32'd1);
`else
    check("t5_ovf_pend", {16'b0, ovf_count}, 32'd5);
`endif
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h5100_0000 + i);
`ifdef USB_ARB_OVF_MARKER_EN
    exp_q.push_back(32'hFF00_0002);
    exp_q.push_back(32'hFF00_0001);
`else
    exp_q.push_back(32'h5E00_0002);
`endif
    out_ready = 1'b1;
    trace_data = 32'h5E00_0001; trace_strobe = 1'b1; tick();
    check("t5_level_pop", {27'b0, fifo_level}, 32'd15);
`ifdef USB_ARB_OVF_MARKER_EN
    check("t5_ovf_popcyc", {16'b0, ovf_count}, 32'd2);
`else
    check("t5_ovf_popcyc", {16'b0, ovf_count}, 32'd6);
`endif
    trace_data = 32'h5E00_0002; tick();
    trace_strobe = 1'b0;
    check("t5_level_next", {27'b0, fifo_level}, 32'd15);
`ifdef USB_ARB_OVF_MARKER_EN
    check("t5_ovf_marker", {16'b0, ovf_count}, 32'd1);
`else
    check("t5_ovf_marker", {16'b0, ovf_count}, 32'd6);
`endif
    tick();
`ifdef USB_ARB_OVF_MARKER_EN
    check("t5_ovf_clear", {16'b0, ovf_count}, 32'd0);
`else
    check("t5_ovf_clear", {16'b0, ovf_count}, 32'd6);
`endif
    wait_drain(60, "t5_drain");
    repeat (3) tick();

    // 6: asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      trace_data = 32'h6000_0000 + i; trace_strobe = 1'b1; tick();
    end
    trace_strobe = 1'b0;
    tick();
    check("t6_level_full", {27'b0, fifo_level}, 32'd16);
`ifdef USB_ARB_OVF_MARKER_EN
    check("t6_ovf", {16'b0, ovf_count}, 32'd3);
`else
    check("t6_ovf", {16'b0, ovf_count}, 32'd9);
`endif
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_level", {27'b0, fifo_level}, 32'd0);
    check("t6_rst_ovf", {16'b0, ovf_count}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    out_ready = 1'b1;
    exp_q.push_back(32'h7777_0001);
    strobe(32'h7777_0001);
    wait_drain(10, "t6_after_reset");
    repeat (2) tick();
    check("end_level", {27'b0, fifo_level}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
